// File: rtl/arcade_input_merge.sv
// Player-input front end: decodes ps2_key events into per-player key state, merges it
// with the hps_io joystick words, and adds SOCD cleaning, autofire and coin stretching.
//
//  state  | meaning
//  C_IDLE | no coin pulse active, waiting for a rising edge on the raw coin input
//  C_HOLD | out_coin high; leaves once the minimum pulse has elapsed and coin is released
module arcade_input_merge #(
    parameter int NUM_PLAYERS   = 2,
    parameter int NUM_BTN       = 4,
    parameter int JOY_START_BIT = 4 + NUM_BTN,
    parameter int JOY_COIN_BIT  = 5 + NUM_BTN,
    parameter int COIN_PULSE    = 4800000,
    parameter int AUTOFIRE_DIV  = 2400000
) (
    input  logic                           clk_sys,
    input  logic                           reset_n,
    input  logic [10:0]                    ps2_key,
    input  logic                           kbd_clear,
    input  logic [16*NUM_PLAYERS-1:0]      joystick,
    input  logic [NUM_PLAYERS-1:0]         autofire_en,
    input  logic                           socd_clean,
    output logic [4*NUM_PLAYERS-1:0]       out_dir,
    output logic [NUM_BTN*NUM_PLAYERS-1:0] out_btn,
    output logic [NUM_PLAYERS-1:0]         out_start,
    output logic [NUM_PLAYERS-1:0]         out_coin
);

    localparam int CW = (COIN_PULSE > 1) ? $clog2(COIN_PULSE) : 1;
    localparam int AW = (AUTOFIRE_DIV > 1) ? $clog2(AUTOFIRE_DIV) : 1;
    localparam logic [CW-1:0] COIN_MAX = CW'(COIN_PULSE - 1);
    localparam logic [AW-1:0] AF_MAX   = AW'(AUTOFIRE_DIV - 1);

    typedef enum logic {C_IDLE = 1'b0, C_HOLD = 1'b1} coin_st_t;

    logic                           tog_q;
    logic [16*NUM_PLAYERS-1:0]      key_state;
    logic [16*NUM_PLAYERS-1:0]      raw;
    logic [AW-1:0]                  af_cnt;
    logic                           af_phase;
    logic [4*NUM_PLAYERS-1:0]       dir_n;
    logic [NUM_BTN*NUM_PLAYERS-1:0] btn_n;
    logic [NUM_PLAYERS-1:0]         start_n;
    logic                           k_hit;
    logic                           k_btn;
    logic                           key_ev;
    int                             k_pl;
    int                             k_bit;
    int                             k_idx;
    logic                           unused_raw;

    // Key positions mirror the joystick word layout so the merge is a plain OR.
    always_comb begin
        k_hit = 1'b1;
        k_btn = 1'b0;
        k_pl  = 0;
        k_bit = 0;
        case ({ps2_key[8], ps2_key[7:0]})
            9'h174: k_bit = 0;
            9'h16B: k_bit = 1;
            9'h172: k_bit = 2;
            9'h175: k_bit = 3;
            9'h014: begin k_btn = 1'b1; k_bit = 4; end
            9'h011: begin k_btn = 1'b1; k_bit = 5; end
            9'h029: begin k_btn = 1'b1; k_bit = 6; end
            9'h012: begin k_btn = 1'b1; k_bit = 7; end
            9'h034: begin k_pl = 1; k_bit = 0; end
            9'h023: begin k_pl = 1; k_bit = 1; end
            9'h02B: begin k_pl = 1; k_bit = 2; end
            9'h02D: begin k_pl = 1; k_bit = 3; end
            9'h01C: begin k_pl = 1; k_btn = 1'b1; k_bit = 4; end
            9'h01B: begin k_pl = 1; k_btn = 1'b1; k_bit = 5; end
            9'h015: begin k_pl = 1; k_btn = 1'b1; k_bit = 6; end
            9'h01D: begin k_pl = 1; k_btn = 1'b1; k_bit = 7; end
            9'h016: begin k_pl = 0; k_bit = JOY_START_BIT; end
            9'h01E: begin k_pl = 1; k_bit = JOY_START_BIT; end
            9'h026: begin k_pl = 2; k_bit = JOY_START_BIT; end
            9'h025: begin k_pl = 3; k_bit = JOY_START_BIT; end
            9'h02E: begin k_pl = 0; k_bit = JOY_COIN_BIT; end
            9'h036: begin k_pl = 1; k_bit = JOY_COIN_BIT; end
            9'h03D: begin k_pl = 2; k_bit = JOY_COIN_BIT; end
            9'h03E: begin k_pl = 3; k_bit = JOY_COIN_BIT; end
            default: k_hit = 1'b0;
        endcase
        k_idx  = 16*k_pl + k_bit;
        key_ev = k_hit && (ps2_key[10] != tog_q) && !kbd_clear && (k_pl < NUM_PLAYERS)
                 && !(k_btn && (k_bit - 4 >= NUM_BTN));
    end

    assign raw        = (kbd_clear ? '0 : key_state) | joystick;
    assign unused_raw = ^raw;

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            tog_q     <= ps2_key[10];
            key_state <= '0;
            af_cnt    <= '0;
            af_phase  <= 1'b0;
            out_dir   <= '0;
            out_btn   <= '0;
            out_start <= '0;
        end else begin
            tog_q <= ps2_key[10];
            if (kbd_clear) begin
                key_state <= '0;
            end else begin
                for (int i = 0; i < 16*NUM_PLAYERS; i++)
                    if (key_ev && i == k_idx) key_state[i] <= ps2_key[9];
            end
            if (af_cnt == AF_MAX) begin
                af_cnt   <= '0;
                af_phase <= ~af_phase;
            end else begin
                af_cnt <= af_cnt + 1'b1;
            end
            out_dir   <= dir_n;
            out_btn   <= btn_n;
            out_start <= start_n;
        end
    end

    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
        localparam int B = 16*p;
        logic [3:0]    r;
        logic          coin_raw;
        logic          prev_q;
        logic [CW-1:0] cnt_q;
        coin_st_t      st_q;

        assign r        = raw[B +: 4];
        assign dir_n[4*p +: 4] = {r[3] & ~(socd_clean & r[2]), r[2] & ~(socd_clean & r[3]),
                                  r[1] & ~(socd_clean & r[0]), r[0] & ~(socd_clean & r[1])};
        assign btn_n[NUM_BTN*p +: NUM_BTN] =
            raw[B+4 +: NUM_BTN] & ~NUM_BTN'(autofire_en[p] & ~af_phase);
        assign start_n[p]  = raw[B+JOY_START_BIT];
        assign coin_raw    = raw[B+JOY_COIN_BIT];
        assign out_coin[p] = (st_q == C_HOLD);

        // Counter saturates instead of restarting, so a re-press never extends the pulse.
        always_ff @(posedge clk_sys) begin
            if (!reset_n) begin
                st_q   <= C_IDLE;
                prev_q <= 1'b0;
                cnt_q  <= '0;
            end else begin
                prev_q <= coin_raw;
                case (st_q)
                    C_IDLE: if (coin_raw && !prev_q) begin
                        st_q  <= C_HOLD;
                        cnt_q <= '0;
                    end
                    C_HOLD: begin
                        if (cnt_q != COIN_MAX) cnt_q <= cnt_q + 1'b1;
                        else if (!coin_raw) st_q <= C_IDLE;
                    end
                    default: st_q <= C_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_arcade_input_merge.sv
// Bench for arcade_input_merge: directed scenarios plus random stimulus against a
// table-driven reference model of key state, SOCD, autofire and coin pulses.
module tb_arcade_input_merge;
    localparam int NP = 2, NB = 4, SB = 8, CB = 9, CP = 10, AD = 4;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic [10:0] ps2_key;
    logic        kbd_clear;
    logic [31:0] joystick;
    logic [1:0]  autofire_en;
    logic        socd_clean;
    logic [7:0]  out_dir;
    logic [7:0]  out_btn;
    logic [1:0]  out_start;
    logic [1:0]  out_coin;

    always #5 clk_sys = ~clk_sys;

    arcade_input_merge #(.NUM_PLAYERS(NP), .NUM_BTN(NB), .JOY_START_BIT(SB), .JOY_COIN_BIT(CB),
                         .COIN_PULSE(CP), .AUTOFIRE_DIV(AD)) dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .ps2_key(ps2_key), .kbd_clear(kbd_clear),
        .joystick(joystick), .autofire_en(autofire_en), .socd_clean(socd_clean),
        .out_dir(out_dir), .out_btn(out_btn), .out_start(out_start), .out_coin(out_coin));

    int checks = 0, errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // {ext, code} keyboard map
    logic [8:0] dir_tab   [2][4] = '{'{9'h174, 9'h16B, 9'h172, 9'h175}, '{9'h034, 9'h023, 9'h02B, 9'h02D}};
    logic [8:0] btn_tab   [2][4] = '{'{9'h014, 9'h011, 9'h029, 9'h012}, '{9'h01C, 9'h01B, 9'h015, 9'h01D}};
    logic [8:0] start_tab [4]    = '{9'h016, 9'h01E, 9'h026, 9'h025};
    logic [8:0] coin_tab  [4]    = '{9'h02E, 9'h036, 9'h03D, 9'h03E};
    logic [8:0] pool      [24]   = '{9'h174, 9'h16B, 9'h172, 9'h175, 9'h014, 9'h011, 9'h029, 9'h012,
                                     9'h034, 9'h023, 9'h02B, 9'h02D, 9'h01C, 9'h01B, 9'h015, 9'h01D,
                                     9'h016, 9'h01E, 9'h026, 9'h02E, 9'h036, 9'h03D, 9'h074, 9'h134};

    logic [15:0] m_key [4];
    logic        m_tog;
    int          m_af, m_n;
    logic        m_prev [2];
    logic        m_in   [2];
    int          m_t0   [2];
    logic [7:0]  e_dir, e_btn;
    logic [1:0]  e_start, e_coin;

    function automatic bit lookup(input logic [8:0] c, output int pl, output int bi);
        lookup = 1'b0; pl = 0; bi = 0;
        for (int p = 0; p < 4; p++) begin
            if (p < 2) for (int j = 0; j < 4; j++) begin
                if (c == dir_tab[p][j]) begin lookup = 1'b1; pl = p; bi = j; end
                if (c == btn_tab[p][j] && j < NB) begin lookup = 1'b1; pl = p; bi = 4 + j; end
            end
            if (c == start_tab[p]) begin lookup = 1'b1; pl = p; bi = SB; end
            if (c == coin_tab[p])  begin lookup = 1'b1; pl = p; bi = CB; end
        end
        if (pl >= NP) lookup = 1'b0;
    endfunction

    // Advances the model by one clock edge using the inputs currently applied.
    task automatic model_edge();
        logic [15:0] r;
        logic        phase;
        int          pl, bi;
        if (!reset_n) begin
            for (int p = 0; p < 4; p++) m_key[p] = '0;
            for (int p = 0; p < 2; p++) begin m_prev[p] = 0; m_in[p] = 0; end
            m_tog = ps2_key[10]; m_af = 0;
            e_dir = '0; e_btn = '0; e_start = '0; e_coin = '0;
            return;
        end
        phase = ((m_af / AD) % 2) == 1;
        m_af++;
        for (int p = 0; p < NP; p++) begin
            r = (kbd_clear ? 16'h0 : m_key[p]) | joystick[16*p +: 16];
            e_dir[4*p +: 4] = r[3:0];
            if (socd_clean && r[0] && r[1]) e_dir[4*p +: 2] = 2'b00;
            if (socd_clean && r[2] && r[3]) e_dir[4*p+2 +: 2] = 2'b00;
            e_btn[4*p +: 4] = r[7:4];
            if (autofire_en[p] && !phase) e_btn[4*p] = 1'b0;
            e_start[p] = r[SB];
            if (!m_in[p]) begin
                if (r[CB] && !m_prev[p]) begin m_in[p] = 1; m_t0[p] = m_n; end
            end else if (m_n - m_t0[p] >= CP && !r[CB]) begin
                m_in[p] = 0;
            end
            m_prev[p] = r[CB];
            e_coin[p] = m_in[p];
        end
        m_n++;
        if (kbd_clear) begin
            for (int p = 0; p < 4; p++) m_key[p] = '0;
        end else if (ps2_key[10] != m_tog && lookup(ps2_key[8:0], pl, bi)) begin
            m_key[pl][bi] = ps2_key[9];
        end
        m_tog = ps2_key[10];
    endtask

    task automatic step();
        model_edge();
        @(posedge clk_sys);
        #1;
        check("dir", out_dir, e_dir);
        check("btn", out_btn, e_btn);
        check("start", out_start, e_start);
        check("coin", out_coin, e_coin);
    endtask

    task automatic send_key(input logic pressed, input logic [8:0] c);
        ps2_key = {~ps2_key[10], pressed, c};
        step();
    endtask

    task automatic coin_run(input int on1, input int gap, input int on2, input int want, input string tag);
        int high = 0;
        for (int i = 0; i < 40; i++) begin
            joystick[CB] = (i < on1) || (i >= on1 + gap && i < on1 + gap + on2);
            step();
            if (out_coin[0]) high++;
        end
        joystick[CB] = 1'b0;
        check(tag, high, want);
    endtask

    initial begin
        reset_n = 0; ps2_key = '0; kbd_clear = 0; joystick = '0; autofire_en = '0; socd_clean = 0;
        m_n = 0;
        repeat (3) step();
        check("reset_outs", {out_dir, out_btn, out_start, out_coin}, 0);
        reset_n = 1;
        step();

        send_key(1, 9'h174); step();
        check("p0_right_press", out_dir[0], 1);
        send_key(0, 9'h174); step();
        check("p0_right_release", out_dir[0], 0);
        send_key(1, 9'h074); step();
        check("no_ext_ignored", out_dir, 0);
        send_key(1, 9'h026); step();
        check("p2_start_ignored", out_start, 0);

        joystick[1:0] = 2'b11; socd_clean = 1; step();
        check("socd_lr_on", out_dir[1:0], 2'b00);
        socd_clean = 0; step();
        check("socd_lr_off", out_dir[1:0], 2'b11);
        joystick = '0; step();

        coin_run(3, 0, 0, CP, "coin_short");
        coin_run(20, 0, 0, 20, "coin_long");
        coin_run(2, 3, 2, CP, "coin_repress");

        begin
            int hi0 = 0, hi1 = 0, run = 0, maxrun = 0;
            autofire_en = 2'b01; joystick[5:4] = 2'b11; step();
            for (int i = 0; i < 16; i++) begin
                step();
                if (out_btn[0]) begin hi0++; run++; end else run = 0;
                if (run > maxrun) maxrun = run;
                if (out_btn[1]) hi1++;
            end
            check("af_btn0_high", hi0, 8);
            check("af_btn0_run", maxrun, 4);
            check("af_btn1_steady", hi1, 16);
            autofire_en = '0; joystick = '0; step();
        end

        send_key(1, 9'h014); send_key(1, 9'h175); step();
        check("keys_held", {out_dir[3], out_btn[0]}, 2'b11);
        kbd_clear = 1; step();
        check("kbd_clear_dir", out_dir, 0);
        check("kbd_clear_btn", out_btn, 0);
        kbd_clear = 0; step(); step();
        check("no_phantom", {out_dir, out_btn}, 0);
        send_key(1, 9'h01C); joystick[CB] = 1; step(); step();
        reset_n = 0; step();
        check("reset_mid", {out_btn, out_coin}, 0);
        joystick[CB] = 0; reset_n = 1; step(); step();
        check("reset_no_phantom", {out_dir, out_btn, out_start, out_coin}, 0);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(3) == 0)
                ps2_key = {~ps2_key[10], 1'($urandom_range(1)), pool[$urandom_range(23)]};
            if ($urandom_range(7) == 0) joystick = $urandom & $urandom & $urandom;
            kbd_clear   = ($urandom_range(31) == 0);
            reset_n     = ($urandom_range(199) != 0);
            socd_clean  = 1'($urandom_range(1));
            if ($urandom_range(63) == 0) autofire_en = 2'($urandom_range(3));
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
